// File: rtl/tone_sequencer.sv
// Table-driven melody player: steps through {freq, dur, mode} entries on a
// tick timebase and drives the DDS frequency select, waveform mode and mute.
module tone_sequencer #(
  parameter int CLK_HZ     = 25000000,
  parameter int TICK_HZ    = 1000,
  parameter int PHASEWIDTH = 48,
  parameter int M_ONE_HZ   = 344,
  parameter int DEPTH      = 16,
  parameter int FREQ_W     = 12,
  parameter int DUR_W      = 10,
  parameter int GAP_TICKS  = 10,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk_25mhz,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [FREQ_W-1:0]     wr_freq,
  input  logic [DUR_W-1:0]      wr_dur,
  input  logic [1:0]            wr_mode,
  input  logic [AW:0]           len,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop,
  output logic [PHASEWIDTH-1:0] fsel,
  output logic [1:0]            mode,
  output logic                  mute,
  output logic                  busy,
  output logic                  done,
  output logic [AW-1:0]         cur_idx
);

  localparam int TICK_DIV = (CLK_HZ / TICK_HZ < 1) ? 1 : CLK_HZ / TICK_HZ;
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GW       = $clog2(GAP_TICKS + 2);
  localparam int CW       = (DUR_W > GW) ? DUR_W : GW;

  typedef enum logic [1:0] {IDLE, NOTE, GAP} state_t;

  state_t                r_state;
  logic [PW-1:0]         r_presc;
  logic [CW-1:0]         r_ticks;
  logic [AW:0]           r_len;
  logic [AW-1:0]         r_idx;
  logic [PHASEWIDTH-1:0] r_fsel;
  logic [1:0]            r_mode;
  logic                  r_mute;
  logic                  r_busy;
  logic                  r_done;

  logic [FREQ_W-1:0]     r_freq_mem [DEPTH];
  logic [DUR_W-1:0]      r_dur_mem  [DEPTH];
  logic [1:0]            r_mode_mem [DEPTH];

  logic [AW:0]           w_idx_inc;
  logic                  w_more;
  logic [AW-1:0]         w_rd_idx;
  logic [FREQ_W-1:0]     w_rd_freq;
  logic [DUR_W-1:0]      w_rd_dur;
  logic [1:0]            w_rd_mode;
  logic [PHASEWIDTH-1:0] w_note_fsel;
  logic [CW-1:0]         w_note_ticks;
  logic                  w_tick_end;
  logic [AW:0]           w_eff_len;
  logic                  w_start;

  // Table storage is deliberately unreset; it only accepts writes while idle.
  always_ff @(posedge clk_25mhz) begin
    if (wr_en && r_state == IDLE) begin
      r_freq_mem[wr_addr] <= wr_freq;
      r_dur_mem[wr_addr]  <= wr_dur;
      r_mode_mem[wr_addr] <= wr_mode;
    end
  end

  assign w_idx_inc    = {1'b0, r_idx} + (AW+1)'(1);
  assign w_more       = w_idx_inc < r_len;
  assign w_rd_idx     = (r_state != IDLE && w_more) ? r_idx + AW'(1) : '0;
  assign w_rd_freq    = r_freq_mem[w_rd_idx];
  assign w_rd_dur     = r_dur_mem[w_rd_idx];
  assign w_rd_mode    = r_mode_mem[w_rd_idx];
  assign w_note_fsel  = PHASEWIDTH'((FREQ_W+32)'(w_rd_freq) * (FREQ_W+32)'(M_ONE_HZ));
  assign w_note_ticks = (w_rd_dur == '0) ? CW'(1) : CW'(w_rd_dur);
  assign w_tick_end   = (r_presc == PW'(TICK_DIV - 1));
  assign w_eff_len    = (len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len;
  assign w_start      = start && !stop && (len != '0);

  // r_ticks counts the ticks left in the current NOTE or GAP, including the one in progress.
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_presc <= '0;
      r_ticks <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_fsel  <= '0;
      r_mode  <= '0;
      r_mute  <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_len   <= w_eff_len;
            r_busy  <= 1'b1;
            r_state <= NOTE;
            r_idx   <= w_rd_idx;
            r_fsel  <= w_note_fsel;
            r_mode  <= w_rd_mode;
            r_mute  <= (w_rd_freq == '0);
            r_ticks <= w_note_ticks;
            r_presc <= '0;
          end
        end
        default: begin
          if (stop) begin
            r_state <= IDLE;
            r_mute  <= 1'b1;
            r_busy  <= 1'b0;
          end else if (!w_tick_end) begin
            r_presc <= r_presc + PW'(1);
          end else begin
            r_presc <= '0;
            if (r_ticks != CW'(1)) begin
              r_ticks <= r_ticks - CW'(1);
            end else if (r_state == NOTE && GAP_TICKS != 0) begin
              r_state <= GAP;
              r_mute  <= 1'b1;
              r_ticks <= CW'(GAP_TICKS);
            end else if (w_more || loop) begin
              r_state <= NOTE;
              r_idx   <= w_rd_idx;
              r_fsel  <= w_note_fsel;
              r_mode  <= w_rd_mode;
              r_mute  <= (w_rd_freq == '0);
              r_ticks <= w_note_ticks;
            end else begin
              r_state <= IDLE;
              r_mute  <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign fsel    = r_fsel;
  assign mode    = r_mode;
  assign mute    = r_mute;
  assign busy    = r_busy;
  assign done    = r_done;
  assign cur_idx = r_idx;

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: two instances (one-tick gap and no gap) checked each
// cycle against a per-cycle timeline built from the note table.
module tb_tone_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [11:0] wr_freq;
  logic [9:0]  wr_dur;
  logic [1:0]  wr_mode;
  logic [4:0]  len;
  logic        start, stop, loop;
  logic        loop0;

  logic [47:0] fselA, fselB;
  logic [1:0]  modeA, modeB;
  logic        muteA, muteB, busyA, busyB, doneA, doneB;
  logic [3:0]  idxA, idxB;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tone_sequencer #(.CLK_HZ(1000), .TICK_HZ(100), .GAP_TICKS(1)) dutA (
    .clk_25mhz(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_freq(wr_freq), .wr_dur(wr_dur), .wr_mode(wr_mode), .len(len),
    .start(start), .stop(stop), .loop(loop), .fsel(fselA), .mode(modeA),
    .mute(muteA), .busy(busyA), .done(doneA), .cur_idx(idxA));

  tone_sequencer #(.CLK_HZ(1000), .TICK_HZ(100), .GAP_TICKS(0)) dutB (
    .clk_25mhz(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_freq(wr_freq), .wr_dur(wr_dur), .wr_mode(wr_mode), .len(len),
    .start(start), .stop(stop), .loop(loop0), .fsel(fselB), .mode(modeB),
    .mute(muteB), .busy(busyB), .done(doneB), .cur_idx(idxB));

  typedef struct {
    logic [47:0] fsel;
    logic [1:0]  mode;
    logic        mute;
    logic        busy;
    logic        done;
    logic [3:0]  idx;
    bit          chkVal;
  } exp_t;
  typedef exp_t expq_t[$];

  int mFreq [16];
  int mDur  [16];
  int mMode [16];

  function automatic exp_t idleRec(bit isReset);
    exp_t r;
    r.fsel = '0; r.mode = '0; r.mute = 1'b1; r.busy = 1'b0;
    r.done = 1'b0; r.idx = '0; r.chkVal = isReset;
    return r;
  endfunction

  function automatic int noteCycles(int i);
    return ((mDur[i] == 0) ? 1 : mDur[i]) * 10;
  endfunction

  function automatic int passCycles(int effLen, int gapTicks);
    int n = 0;
    for (int i = 0; i < effLen; i++) n += noteCycles(i) + gapTicks * 10;
    return n;
  endfunction

  // Expected outputs for every cycle after the start edge, ending with the done pulse.
  function automatic expq_t buildQ(int effLen, int passes, int gapTicks);
    expq_t q;
    exp_t  r;
    r = idleRec(1'b0);
    for (int p = 0; p < passes; p++) begin
      for (int i = 0; i < effLen; i++) begin
        r.fsel   = 48'(mFreq[i] * 344);
        r.mode   = 2'(mMode[i]);
        r.mute   = (mFreq[i] == 0);
        r.busy   = 1'b1;
        r.done   = 1'b0;
        r.idx    = 4'(i);
        r.chkVal = 1'b1;
        repeat (noteCycles(i)) q.push_back(r);
        r.mute = 1'b1;
        repeat (gapTicks * 10) q.push_back(r);
      end
    end
    r.mute = 1'b1; r.busy = 1'b0; r.done = 1'b1;
    q.push_back(r);
    return q;
  endfunction

  function automatic expq_t truncQ(expq_t q, int stopAt);
    expq_t t;
    if (stopAt < 0 || stopAt >= q.size()) return q;
    for (int i = 0; i < stopAt; i++) t.push_back(q[i]);
    t.push_back(idleRec(1'b0));
    return t;
  endfunction

  task automatic checkField(input string tag, input logic [47:0] got, input logic [47:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic checkOutput(input string who, input int cyc, input exp_t e,
                             input logic [47:0] gf, input logic [1:0] gm, input logic gmu,
                             input logic gb, input logic gd, input logic [3:0] gi);
    checkField($sformatf("%s.mute@%0d", who, cyc), 48'(gmu), 48'(e.mute));
    checkField($sformatf("%s.busy@%0d", who, cyc), 48'(gb), 48'(e.busy));
    checkField($sformatf("%s.done@%0d", who, cyc), 48'(gd), 48'(e.done));
    if (e.busy) checkField($sformatf("%s.idx@%0d", who, cyc), 48'(gi), 48'(e.idx));
    if (e.chkVal) begin
      checkField($sformatf("%s.fsel@%0d", who, cyc), gf, e.fsel);
      checkField($sformatf("%s.mode@%0d", who, cyc), 48'(gm), 48'(e.mode));
    end
  endtask

  task automatic checkBoth(input int cyc, input exp_t ea, input exp_t eb);
    checkOutput("A", cyc, ea, fselA, modeA, muteA, busyA, doneA, idxA);
    checkOutput("B", cyc, eb, fselB, modeB, muteB, busyB, doneB, idxB);
  endtask

  task automatic applyStimulus(input int addr, input int f, input int d, input int m);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'(addr); wr_freq = 12'(f); wr_dur = 10'(d); wr_mode = 2'(m);
    mFreq[addr] = f; mDur[addr] = d; mMode[addr] = m;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Starts playback and checks both instances every cycle; optional loop drop,
  // stop, and an intrusive write+start while busy at the given cycle offsets.
  task automatic playCheck(input int lenIn, input int dropLoopAt, input int stopAt, input int intrudeAt);
    expq_t qa, qb;
    int    effLen, n;
    effLen = (lenIn > 16) ? 16 : lenIn;
    qa = truncQ(buildQ(effLen, (dropLoopAt >= 0) ? 2 : 1, 1), stopAt);
    qb = truncQ(buildQ(effLen, 1, 0), stopAt);
    n  = ((qa.size() > qb.size()) ? qa.size() : qb.size()) + 3;
    @(negedge clk);
    len = 5'(lenIn); loop = (dropLoopAt >= 0); start = 1'b1;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (c == 0) start = 1'b0;
      checkBoth(c, (c < qa.size()) ? qa[c] : idleRec(1'b0),
                   (c < qb.size()) ? qb[c] : idleRec(1'b0));
      if (c == dropLoopAt) loop = 1'b0;
      stop = (c == stopAt - 1);
      if (c == intrudeAt) begin
        wr_en = 1'b1; wr_addr = 4'd0; wr_freq = 12'd1000; wr_dur = 10'd5; wr_mode = 2'd0;
        start = 1'b1;
      end else if (c == intrudeAt + 1) begin
        wr_en = 1'b0; start = 1'b0;
      end
    end
  endtask

  task automatic checkIdleCycles(input int cycles, input bit isReset);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      checkBoth(1000 + c, idleRec(isReset), idleRec(isReset));
    end
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_freq = '0; wr_dur = '0; wr_mode = '0;
    len = '0; start = 1'b0; stop = 1'b0; loop = 1'b0; loop0 = 1'b0;

    repeat (3) @(negedge clk);
    checkBoth(-1, idleRec(1'b1), idleRec(1'b1));
    rst_n = 1'b1;
    checkIdleCycles(3, 1'b1);

    $display("[TB] basic sequence");
    applyStimulus(0, 440, 3, 1);
    applyStimulus(1, 0, 2, 2);
    playCheck(2, -1, -1, -1);

    $display("[TB] loop");
    playCheck(2, passCycles(2, 1) + 1, -1, -1);

    $display("[TB] stop mid-note");
    playCheck(2, -1, 12, -1);
    @(negedge clk);
    len = 5'd2; start = 1'b1; stop = 1'b1;
    checkIdleCycles(5, 1'b0);

    $display("[TB] guards");
    @(negedge clk);
    len = 5'd0; start = 1'b1;
    checkIdleCycles(5, 1'b0);
    playCheck(2, -1, -1, 5);
    playCheck(2, -1, -1, -1);

    $display("[TB] edge values");
    applyStimulus(0, 4095, 0, 3);
    applyStimulus(1, 100, 1, 0);
    playCheck(2, -1, -1, -1);

    $display("[TB] randomized tables");
    for (int k = 0; k < 4; k++) begin
      int lenIn, effLen;
      for (int a = 0; a < 16; a++)
        applyStimulus(a, ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 4095)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      lenIn  = (k == 0) ? 31 : int'($urandom_range(1, 31));
      effLen = (lenIn > 16) ? 16 : lenIn;
      playCheck(lenIn, (k == 2) ? passCycles(effLen, 1) + 3 : -1, -1, -1);
    end

    $display("[TB] async reset mid-note");
    @(negedge clk);
    len = 5'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checkBoth(-2, idleRec(1'b1), idleRec(1'b1));
    @(negedge clk);
    rst_n = 1'b1;
    checkIdleCycles(20, 1'b1);
    playCheck(3, -1, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
